// File: rtl/snn_pkg.sv
// Shared types for the SNN presentation controller.
// Sequencer states, timestep length and rate mapping.
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRESENT,
    CLEAR,
    REST,
    DONE
  } state_e;

  localparam int CYCLES_PER_STEP = 2;

  // Left shift that maps a pixel onto a rate word.
  // Top bit of the word stays clear, so full scale is just under 0.5.
  function automatic int rate_shift(input int dw, input int pw);
    return dw - pw - 1;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Window timer for PRESENT and REST.
// Ticks once per timestep, flags the last cycle of the window.
module step_timer
  import snn_pkg::*;
#(
  parameter int STEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [STEP_WIDTH-1:0] steps,
  input  logic                  run,
  output logic                  tick,
  output logic                  expire
);

  localparam int CW = STEP_WIDTH + 1;
  localparam int PW =
    (CYCLES_PER_STEP > 1) ? $clog2(CYCLES_PER_STEP) : 1;

  logic [CW-1:0] win_q, win_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [PW-1:0] ph_q, ph_d;

  assign tick   = run && (ph_q == PW'(CYCLES_PER_STEP - 1));
  assign expire = run && ((cyc_q + 1'b1) == win_q);

  // Window length is captured on load; cycles count while running.
  always_comb begin
    win_d = win_q;
    cyc_d = cyc_q;
    ph_d  = ph_q;
    if (load) begin
      win_d = CW'(steps) * CW'(CYCLES_PER_STEP);
      cyc_d = '0;
      ph_d  = '0;
    end else if (run) begin
      cyc_d = cyc_q + 1'b1;
      ph_d  = tick ? '0 : ph_q + 1'b1;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= '0;
      cyc_q <= '0;
      ph_q  <= '0;
    end else begin
      win_q <= win_d;
      cyc_q <= cyc_d;
      ph_q  <= ph_d;
    end
  end

endmodule

// File: rtl/snn_presentation_controller.sv
// Presentation sequencer for the Bernoulli spike generator:
// load rates, present, clear rates, rest, done.
module snn_presentation_controller
  import snn_pkg::*;
#(
  parameter int NUM_SPIKES     = 32,
  parameter int GEN_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int PIXEL_WIDTH    = 8,
  parameter int STEP_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [STEP_WIDTH-1:0]     present_steps,
  input  logic [STEP_WIDTH-1:0]     rest_steps,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic [PIXEL_WIDTH-1:0]    pix_data,
  output logic [GEN_ADDR_WIDTH-1:0] gen_addr,
  output logic                      gen_wen,
  output logic [DATA_WIDTH-1:0]     gen_wdata,
  output logic                      present_active,
  output logic                      busy,
  output logic                      done,
  output logic [STEP_WIDTH-1:0]     step_count
);

  localparam int IW = GEN_ADDR_WIDTH + 1;
  localparam int SH = rate_shift(DATA_WIDTH, PIXEL_WIDTH);
  localparam logic [IW-1:0] N = IW'(NUM_SPIKES);

  state_e state_q, state_d;
  logic [STEP_WIDTH-1:0] pres_q, pres_d;
  logic [STEP_WIDTH-1:0] rest_q, rest_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] clr_q, clr_d;
  logic [GEN_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic ready_q, ready_d;
  logic wen_q, wen_d;
  logic act_q, act_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic hs, win_now, win_nxt;
  logic t_load, t_run, t_tick, t_expire;
  logic [STEP_WIDTH-1:0] t_steps;

  assign hs      = (state_q == LOAD) && ready_q && pix_valid;
  assign t_run   = act_q || (state_q == REST);
  assign t_steps = (state_q == LOAD) ? pres_q : rest_q;
  assign t_load  =
    ((state_q == LOAD) && (state_d == PRESENT)) ||
    ((state_q == CLEAR) && (state_d == REST));

  step_timer #(
    .STEP_WIDTH(STEP_WIDTH)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (t_load),
    .steps (t_steps),
    .run   (t_run),
    .tick  (t_tick),
    .expire(t_expire)
  );

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    pres_d  = pres_q;
    rest_d  = rest_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          pres_d  = present_steps;
          rest_d  = rest_steps;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (hs) idx_d = idx_q + 1'b1;
        if (abort) state_d = CLEAR;
        else if (hs && idx_q == N - 1'b1) state_d = PRESENT;
      end
      PRESENT: begin
        if (abort || t_expire) state_d = CLEAR;
        else if (!act_q && pres_q == '0) state_d = CLEAR;
      end
      CLEAR: begin
        if (clr_q == N) state_d = (rest_q == '0) ? DONE : REST;
      end
      REST: begin
        if (t_expire) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs; a pending pixel write beats the first clear write.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    clr_d   = (state_d == CLEAR) ? clr_q : '0;
    if (hs) begin
      wen_d   = 1'b1;
      addr_d  = idx_q[GEN_ADDR_WIDTH-1:0];
      wdata_d = DATA_WIDTH'(pix_data) << SH;
    end else if (state_d == CLEAR) begin
      wen_d   = 1'b1;
      addr_d  = clr_q[GEN_ADDR_WIDTH-1:0];
      wdata_d = '0;
      clr_d   = clr_q + 1'b1;
    end
    ready_d = (state_d == LOAD) && (idx_d < N);
    act_d   = (state_d == PRESENT) && (state_q == PRESENT);
    busy_d  = state_d != IDLE;
    done_d  = state_d == DONE;
    win_now = act_q || (state_q == REST);
    win_nxt = act_d || (state_d == REST);
    step_d  = '0;
    if (win_nxt && win_now) step_d = step_q + STEP_WIDTH'(t_tick);
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pres_q  <= '0;
      rest_q  <= '0;
      step_q  <= '0;
      idx_q   <= '0;
      clr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      wen_q   <= 1'b0;
      act_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pres_q  <= pres_d;
      rest_q  <= rest_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      clr_q   <= clr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      wen_q   <= wen_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pix_ready      = ready_q;
  assign gen_wen        = wen_q;
  assign gen_addr       = addr_q;
  assign gen_wdata      = wdata_q;
  assign present_active = act_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign step_count     = step_q;

endmodule

// File: tb/tb_snn_presentation_controller.sv
// Randomized bench for the presentation sequencer.
// Expectations come from a timeline model of the sequence.
module tb_snn_presentation_controller;

  localparam int NS = 32;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int PW = 8;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic pix_valid = 1'b0;
  logic [SW-1:0] present_steps = '0;
  logic [SW-1:0] rest_steps = '0;
  logic [PW-1:0] pix_data = '0;
  logic pix_ready, gen_wen, present_active, busy, done;
  logic [AW-1:0] gen_addr;
  logic [DW-1:0] gen_wdata;
  logic [SW-1:0] step_count;

  int n_vec = 0;
  int n_bad = 0;
  int last_addr = 0;

  always #5 clk = ~clk;

  snn_presentation_controller #(
    .NUM_SPIKES(NS),
    .GEN_ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .PIXEL_WIDTH(PW),
    .STEP_WIDTH(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .present_steps(present_steps),
    .rest_steps(rest_steps),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data(pix_data),
    .gen_addr(gen_addr),
    .gen_wen(gen_wen),
    .gen_wdata(gen_wdata),
    .present_active(present_active),
    .busy(busy),
    .done(done),
    .step_count(step_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    n_vec++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, pix_ready, 0);
    chk({tag, "_wen"}, gen_wen, 0);
    chk({tag, "_addr"}, gen_addr, 0);
    chk({tag, "_wdata"}, gen_wdata, 0);
    chk({tag, "_active"}, present_active, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_step"}, step_count, 0);
  endtask

  // p/r: window lengths. vmode: 0 always valid, 1 1001 pattern,
  // 2 random. ab_rel: abort at cycle E+ab_rel (E = first PRESENT cycle).
  // ab_hs: abort in LOAD after that many handshakes.
  // rst_hs: reset after that many handshakes. sb_rel: start at E+sb_rel.
  task automatic run(input int p, input int r, input int vmode,
                     input int ab_rel, input int ab_hs,
                     input int rst_hs, input int sb_rel);
    int k, n_hs, e, c, d, w_addr, x_addr, x_step;
    bit w_pend, ld, act, inrest, hs, stop, x_wen;
    logic [DW-1:0] w_data, x_data;
    k = 0; n_hs = 0; e = -1; c = -1;
    w_pend = 0; w_addr = 0; w_data = '0; stop = 0;
    @(negedge clk);
    start = 1'b1;
    present_steps = SW'(p);
    rest_steps = SW'(r);
    @(negedge clk);
    start = 1'b0;
    present_steps = SW'($urandom);
    rest_steps = SW'($urandom);
    while (!stop) begin
      ld = (e < 0 && c < 0);
      x_data = '0;
      if (w_pend) begin
        x_wen = 1; x_addr = w_addr; x_data = w_data;
      end else if (c >= 0 && k >= c && k < c + NS) begin
        x_wen = 1; x_addr = k - c;
      end else begin
        x_wen = 0; x_addr = last_addr;
      end
      act = (e >= 0 && k > e && k < c);
      d = (c >= 0) ? c + NS + 2 * r : -1;
      inrest = (c >= 0 && k >= c + NS && k < d);
      x_step = act ? (k - e - 1) / 2 : inrest ? (k - c - NS) / 2 : 0;
      chk("pix_ready", pix_ready, ld);
      chk("gen_wen", gen_wen, x_wen);
      chk("gen_addr", gen_addr, x_addr);
      if (x_wen) chk("gen_wdata", gen_wdata, x_data);
      chk("present_active", present_active, act);
      chk("step_count", step_count, x_step);
      chk("done", done, (d >= 0 && k == d));
      chk("busy", busy, !(d >= 0 && k > d));
      last_addr = x_addr;
      if (d >= 0 && k >= d + 3) stop = 1;
      if (k > 3000) begin
        chk("timeout", 1, 0);
        stop = 1;
      end
      if (rst_hs > 0 && n_hs == rst_hs) begin
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        last_addr = 0;
        pix_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("post_rst_wen", gen_wen, 0);
          chk("post_rst_busy", busy, 0);
        end
        return;
      end
      case (vmode)
        0: pix_valid = 1'b1;
        1: pix_valid = (k % 4 == 0) || (k % 4 == 3);
        default: pix_valid = 1'($urandom_range(0, 1));
      endcase
      pix_data = (vmode == 0) ? PW'(n_hs) : PW'($urandom);
      abort = 1'b0;
      if (ab_rel >= 0 && e >= 0 && k == e + ab_rel) abort = 1'b1;
      if (ab_hs > 0 && ld && n_hs == ab_hs) abort = 1'b1;
      start = (sb_rel >= 0 && e >= 0 && k == e + sb_rel);
      if (start) begin
        present_steps = SW'($urandom_range(1, 9));
        rest_steps = SW'($urandom_range(1, 9));
      end
      hs = ld && pix_valid;
      w_pend = hs;
      if (hs) begin
        w_addr = n_hs;
        w_data = DW'(pix_data) * DW'(2 ** (DW - PW - 1));
        n_hs++;
      end
      if (abort && ld) c = k + 1 + (hs ? 1 : 0);
      else if (abort && e >= 0 && k < c) c = k + 1;
      else if (hs && n_hs == NS) begin
        e = k + 1;
        c = e + 2 * p + 1;
      end
      k++;
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    pix_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    #12 chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 chk_zero("reset_release");
    run(3, 2, 0, -1, -1, -1, -1);
    run(2, 1, 1, -1, -1, -1, -1);
    run(0, 0, 0, -1, -1, -1, -1);
    run(4, 3, 2, 3, -1, -1, -1);
    run(2, 2, 0, -1, -1, 10, -1);
    run(1, 1, 0, -1, -1, -1, -1);
    run(5, 2, 2, -1, -1, -1, 2);
    run(2, 1, 2, -1, 7, -1, -1);
    run(2, 1, 0, -1, 5, -1, -1);
    for (int i = 0; i < 4; i++) begin
      run($urandom_range(0, 4), $urandom_range(0, 3), 2,
          -1, -1, -1, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/snn_presentation_controller.md
Name: snn_presentation_controller

Overview:
- Sequences one input presentation for the Bernoulli spike generator.
- Streams NUM_SPIKES pixel intensities in and converts each to a firing-probability word.
- Writes each word into the generator's rate memory over its address/write-enable/data port.
- Holds the presentation window for a programmable number of timesteps, zeroes all rates, runs a rest window, then signals done. Sits between the host/pixel-DMA path and the spike generator; gates downstream neuron update via present_active.

Parameters:
- NUM_SPIKES, 32, number of input channels / generator rate entries
- GEN_ADDR_WIDTH, 5, generator rate-memory address width (must satisfy 2**GEN_ADDR_WIDTH >= NUM_SPIKES)
- DATA_WIDTH, 32, generator rate word width
- PIXEL_WIDTH, 8, input intensity width
- STEP_WIDTH, 16, timestep counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a presentation; sampled only in IDLE
- abort  in  1  terminate LOAD/PRESENT early; go to CLEAR
- present_steps  in  STEP_WIDTH  presentation length in timesteps; latched at start
- rest_steps  in  STEP_WIDTH  rest length in timesteps; latched at start
- pix_valid  in  1  pixel stream valid
- pix_ready  out  1  pixel stream ready
- pix_data  in  PIXEL_WIDTH  pixel intensity
- gen_addr  out  GEN_ADDR_WIDTH  generator memory address
- gen_wen  out  1  generator memory write enable
- gen_wdata  out  DATA_WIDTH  generator rate word
- present_active  out  1  high during presentation timesteps
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of sequence
- step_count  out  STEP_WIDTH  completed timesteps in the current PRESENT or REST window

Behaviour:
- Reset: state IDLE.
  - All outputs 0: pix_ready, gen_wen, gen_addr, gen_wdata, present_active, busy, done, step_count.
  - Internal index and cycle counters are cleared.
  - Reset mid-sequence performs no further writes; generator memory keeps whatever was last written.
- Timestep definition: 2 clk cycles, matching the generator's alternating spike phase. Window of N steps = 2N cycles.
- States: IDLE -> LOAD -> PRESENT -> CLEAR -> REST -> DONE -> IDLE.
- IDLE:
  - start=1 latches present_steps and rest_steps, clears the index, and enters LOAD.
  - start in any other state is ignored.
- LOAD:
  - pix_ready=1 while index < NUM_SPIKES.
  - Each handshake (pix_valid & pix_ready at a clk edge) registers the write; it appears on the next cycle as gen_wen=1, gen_addr=index, gen_wdata=pix_data << (DATA_WIDTH-PIXEL_WIDTH-1).
  - Intensity 255 therefore maps to 0x7F80_0000 (probability of about 0.5); intensity 0 maps to 0.
  - Index increments per handshake. pix_valid gaps stall LOAD indefinitely.
  - After the handshake with index = NUM_SPIKES-1, pix_ready drops the next cycle and the state moves to PRESENT. The final write is issued in PRESENT's first cycle.
- PRESENT:
  - present_active=1 from the cycle after entry for 2*present_steps cycles.
  - step_count increments after every second cycle.
  - present_steps=0 skips straight to CLEAR; present_active never asserts.
- CLEAR:
  - Writes gen_wdata=0 to addresses 0..NUM_SPIKES-1, one per cycle, gen_wen=1 throughout: NUM_SPIKES cycles.
  - Then enters REST.
- REST:
  - 2*rest_steps cycles, present_active=0, step_count counts from 0.
  - rest_steps=0 skips to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE. busy falls in the same cycle that IDLE is entered.
- abort:
  - In LOAD or PRESENT: next state is CLEAR and present_active drops the next cycle.
  - Any write registered from a same-cycle handshake is still issued.
  - abort in CLEAR, REST, DONE or IDLE is ignored.
  - Abort during LOAD with partial data still clears all entries.
- gen_wen is never asserted outside LOAD (the delayed write), the first PRESENT cycle, and CLEAR.
- gen_addr holds its last value when gen_wen=0.
- Counters are wide enough that no wrap occurs: present_steps = 2**STEP_WIDTH-1 is legal, and the cycle counter is STEP_WIDTH+1 bits.

Decomposition:
- Shared package snn_pkg:
  - state enum (IDLE, LOAD, PRESENT, CLEAR, REST, DONE)
  - CYCLES_PER_STEP = 2
  - intensity-to-rate shift constant
- Sub-module step_timer: loads a step count, emits a tick every CYCLES_PER_STEP cycles and an expire pulse. It is reused by PRESENT and REST.

Test Plan:
- Nominal: NUM_SPIKES=32, present_steps=3, rest_steps=2, pixels 0..31 streamed back-to-back.
  - 32 writes with gen_wdata[k] = k<<23.
  - present_active high for 6 cycles.
  - 32 zero writes.
  - 4 rest cycles, then done one cycle; busy falls with done's following cycle.
- Stalled stream: pix_valid toggles 1,0,0,1 pattern.
  - Write count is still 32, with addresses strictly sequential.
  - No write occurs in stall cycles.
- Zero windows: present_steps=0, rest_steps=0.
  - present_active never high.
  - CLEAR follows the last write immediately.
  - done occurs the cycle after the last clear write.
- Abort: abort at PRESENT step 1.
  - present_active low the next cycle.
  - 32 zero writes, full REST, then done.
- Reset mid-LOAD: rst asserted after 10 handshakes.
  - All outputs are 0 immediately (asynchronous).
  - No further gen_wen.
  - A subsequent start runs normally from address 0.
- Start while busy: start pulsed during PRESENT has no effect.
  - Latched step counts are unchanged.
  - Only one done pulse.
